// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, NOP encoding,
// instruction field positions and the default reset PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StIssue
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int unsigned OP_LSB      = 0;
  localparam int unsigned OP_MSB      = 6;
  localparam int unsigned FUNCT3_LSB  = 12;
  localparam int unsigned FUNCT3_MSB  = 14;
  localparam int unsigned FUNCT7B5_BIT = 30;

endpackage

// File: rtl/fetch_unit_next_pc_gen.sv
// Combinational next-PC selection for the fetch stage. FETCH_MISALIGN_TRAP_EN
// redirects targets with bit 1 set to TRAP_VEC and flags a trap.
module next_pc_gen
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            trap_o
);

  logic [XLEN-1:0] target_aligned;

  assign pc_plus4_o     = pc_i + XLEN'(4);
  assign target_aligned = {pc_target_i[XLEN-1:1], 1'b0};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic unused_bits;
  assign unused_bits = pc_target_i[0];

  always_comb begin
    trap_o    = 1'b0;
    next_pc_o = pc_plus4_o;
    if (pc_src_i) begin
      if (pc_target_i[1]) begin
        trap_o    = 1'b1;
        next_pc_o = TRAP_VEC;
      end else begin
        next_pc_o = target_aligned;
      end
    end
  end
`else
  // Bit 0 of the target and the trap vector have no effect in this build.
  logic unused_bits;
  assign unused_bits = ^{pc_target_i[0], TRAP_VEC};

  assign trap_o    = 1'b0;
  assign next_pc_o = pc_src_i ? target_aligned : pc_plus4_o;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/valid handshake and
// holds the fetched word for decode. Misaligned-target trap: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            resetN,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemValid,
  input  logic [31:0]     imemRdata,
  output logic            instrValid,
  input  logic            instrAccept,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7B5,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] pcTarget,
  output logic            trap
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            instr_valid_q;
  logic            imem_req_q;
  logic            trap_q;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            next_trap;

  next_pc_gen #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_pc_gen (
    .pc_i        (pc_q),
    .pc_src_i    (pcSrc),
    .pc_target_i (pcTarget),
    .pc_plus4_o  (pc_plus4),
    .next_pc_o   (next_pc),
    .trap_o      (next_trap)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      case (state_q)
        StBoot: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StFetch: begin
          if (imemValid) begin
            instr_q       <= imemRdata;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          // pcSrc/pcTarget only matter on the accepting cycle.
          if (instrAccept) begin
            pc_q          <= next_pc;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            trap_q        <= next_trap;
            state_q       <= StFetch;
          end
        end
        default: begin
          state_q       <= StBoot;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imemReq    = imem_req_q;
  assign imemAddr   = pc_q;
  assign instrValid = instr_valid_q;
  assign instr      = instr_q;
  assign op         = instr_q[OP_MSB:OP_LSB];
  assign funct3     = instr_q[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7B5   = instr_q[FUNCT7B5_BIT];
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign trap       = trap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: boot, wait states, stall,
// branch/sequential redirect, PC wrap, misaligned target and mid-fetch reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic        instrAccept;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7B5;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        pcSrc;
  logic [31:0] pcTarget;
  logic        trap;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemValid   (imemValid),
    .imemRdata   (imemRdata),
    .instrValid  (instrValid),
    .instrAccept (instrAccept),
    .instr       (instr),
    .op          (op),
    .funct3      (funct3),
    .funct7B5    (funct7B5),
    .pc          (pc),
    .pcPlus4     (pcPlus4),
    .pcSrc       (pcSrc),
    .pcTarget    (pcTarget),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_word(input logic [31:0] data);
    imemValid = 1'b1;
    imemRdata = data;
    tick();
    imemValid = 1'b0;
    imemRdata = 32'h0;
  endtask

  task automatic accept(input logic src, input logic [31:0] tgt);
    instrAccept = 1'b1;
    pcSrc       = src;
    pcTarget    = tgt;
    tick();
    instrAccept = 1'b0;
    pcSrc       = 1'b0;
    pcTarget    = 32'h0;
  endtask

  initial begin
    resetN      = 1'b0;
    imemValid   = 1'b0;
    imemRdata   = 32'h0;
    instrAccept = 1'b0;
    pcSrc       = 1'b0;
    pcTarget    = 32'h0;

    // Reset and boot
    repeat (3) tick();
    check("rst_req", 64'(imemReq), 64'd0);
    check("rst_valid", 64'(instrValid), 64'd0);
    check("rst_instr", 64'(instr), 64'h13);
    check("rst_pc", 64'(pc), 64'h0);
    check("rst_trap", 64'(trap), 64'd0);
    resetN = 1'b1;
    tick();
    check("boot_req", 64'(imemReq), 64'd1);
    check("boot_addr", 64'(imemAddr), 64'h0);

    // Zero-wait fetch
    fetch_word(32'h0000_0503);
    check("zw_valid", 64'(instrValid), 64'd1);
    check("zw_req", 64'(imemReq), 64'd0);
    check("zw_op", 64'(op), 64'h03);
    check("zw_funct3", 64'(funct3), 64'd0);
    check("zw_pc", 64'(pc), 64'h0);
    check("zw_pcplus4", 64'(pcPlus4), 64'h4);
    accept(1'b0, 32'h0);
    check("seq_addr", 64'(imemAddr), 64'h4);
    check("seq_req_valid", {62'd0, imemReq, instrValid}, 64'b10);

    // Wait states: address and request held
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_addr_req", {31'd0, imemReq, imemAddr}, {31'd0, 1'b1, 32'h4});
    end
    fetch_word(32'h4000_0033);
    check("ws_funct7b5", 64'(funct7B5), 64'd1);
    check("ws_op", 64'(op), 64'h33);
    check("ws_pc", 64'(pc), 64'h4);

    // Stall in ISSUE; imemValid and pcSrc must be ignored
    imemValid = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    pcSrc     = 1'b1;
    pcTarget  = 32'h0000_0080;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold", {instr, pc}, {32'h4000_0033, 32'h4});
      check("stall_ctl", {61'd0, instrValid, imemReq, trap}, 64'b100);
    end
    imemValid = 1'b0;
    pcSrc     = 1'b0;
    accept(1'b0, 32'h0);
    check("stall_next", 64'(imemAddr), 64'h8);

    // Branch from pc=8 to 0x41 -> bit 0 cleared
    fetch_word(32'h0000_0063);
    check("br_pc", 64'(pc), 64'h8);
    accept(1'b1, 32'h0000_0041);
    check("br_addr", 64'(imemAddr), 64'h40);
    // instrAccept/pcSrc outside ISSUE ignored
    instrAccept = 1'b1;
    pcSrc       = 1'b1;
    pcTarget    = 32'h0000_0080;
    tick();
    check("fetch_ign_acc", {31'd0, imemReq, imemAddr}, {31'd0, 1'b1, 32'h40});
    instrAccept = 1'b0;
    pcSrc       = 1'b0;
    fetch_word(32'h0000_0013);
    accept(1'b1, 32'h0000_0008);
    check("br_back", 64'(imemAddr), 64'h8);
    fetch_word(32'h0000_0013);
    accept(1'b0, 32'h0000_0041);
    check("nobr_addr", 64'(imemAddr), 64'hC);

    // Wrap at top of address space
    fetch_word(32'h0000_0013);
    accept(1'b1, 32'hFFFF_FFFD);
    check("hi_addr", 64'(imemAddr), 64'hFFFF_FFFC);
    fetch_word(32'h0000_0013);
    check("wrap_pcplus4", 64'(pcPlus4), 64'h0);
    accept(1'b0, 32'h0);
    check("wrap_addr", 64'(imemAddr), 64'h0);

    // Target with bit 1 set
    fetch_word(32'h0000_0013);
    accept(1'b1, 32'h0000_0012);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_trap", 64'(trap), 64'd1);
    check("mis_addr", 64'(imemAddr), 64'h100);
`else
    check("mis_trap", 64'(trap), 64'd0);
    check("mis_addr", 64'(imemAddr), 64'h12);
`endif
    tick();
    check("mis_trap_end", 64'(trap), 64'd0);

    // Mid-fetch reset at pc=0x20, with data arriving as reset hits
    fetch_word(32'h0000_0013);
    accept(1'b1, 32'h0000_0020);
    check("mf_addr", {31'd0, imemReq, imemAddr}, {31'd0, 1'b1, 32'h20});
    imemValid = 1'b1;
    imemRdata = 32'hCAFE_F00D;
    resetN    = 1'b0;
    #1;
    check("mf_rst_async", {30'd0, imemReq, instrValid, pc}, {30'd0, 2'b00, 32'h0});
    tick();
    imemValid = 1'b0;
    resetN    = 1'b1;
    check("mf_rst_instr", 64'(instr), 64'h13);
    tick();
    check("mf_restart", {31'd0, imemReq, imemAddr}, {31'd0, 1'b1, 32'h0});
    check("mf_no_valid", 64'(instrValid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
